// File: rtl/vector_lsu_strided.sv
// vector_lsu_strided
//
// Memory-stage load/store sequencer. A vector access of L lanes is broken
// into L single-word transactions on the data memory port, one lane per
// cycle, with lane addresses spaced by a signed byte stride and gated by a
// per-lane enable mask. The pipeline is frozen while the lanes are issued.
// Scalar accesses bypass the sequencer combinationally with no added latency.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous, active-low reset
//   req_valid      memory-stage instruction performs a memory access
//   req_write      1 = store, 0 = load
//   req_vector     1 = vector access, 0 = scalar access
//   base_addr      byte address of lane 0 (scalar: the access address)
//   stride         signed byte stride between consecutive lanes
//   lane_mask      bit i enables lane i (vector only)
//   wdata          store data, lane i in bits [N*i+N-1 : N*i]
//   mem_rdata      asynchronous read data for the current m_address
//   stall_cpu      freezes PC and all pipe registers
//   mem_wen_output data memory write enable
//   m_address      data memory byte address
//   to_mem_data    data memory write data
//   output_vector  load result towards the writeback pipe
//   done           single-cycle pulse when a vector access completes
//   addr_fault     sticky: an enabled lane addressed above ADDR_MAX

module vector_lsu_strided #(
    parameter int            N        = 32,
    parameter int            L        = 4,
    parameter logic [N-1:0]  ADDR_MAX = 32'h3D08F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_vector,
    input  logic [N-1:0]     base_addr,
    input  logic [N-1:0]     stride,
    input  logic [L-1:0]     lane_mask,
    input  logic [N*L-1:0]   wdata,
    input  logic [N-1:0]     mem_rdata,
    output logic             stall_cpu,
    output logic             mem_wen_output,
    output logic [N-1:0]     m_address,
    output logic [N-1:0]     to_mem_data,
    output logic [N*L-1:0]   output_vector,
    output logic             done,
    output logic             addr_fault
);

    localparam int             V         = N * L;
    localparam int             LW        = $clog2(L);
    localparam logic [LW-1:0]  LAST_LANE = LW'(L - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LW-1:0]   lane_q;
    logic [N-1:0]    addr_q;
    logic [N-1:0]    stride_q;
    logic [L-1:0]    mask_q;
    logic [V-1:0]    wdata_q;
    logic            write_q;
    logic [V-1:0]    result_q;
    logic            fault_q;

    logic            lane_en;
    logic            lane_in_range;
    logic            scalar_in_range;

    // Per-lane qualifiers for the lane currently being issued. addr_q walks
    // base + i*stride by accumulation, so the address wraps mod 2^N for free.
    always_comb begin
        lane_en         = mask_q[lane_q];
        lane_in_range   = (addr_q <= ADDR_MAX);
        scalar_in_range = (base_addr <= ADDR_MAX);
    end

    // Sequencer state and datapath registers. The captured request fields
    // are deliberately left out of reset; they are reloaded at every vector
    // capture and nothing reads them outside XFER. Out-of-range or masked
    // lanes write zero into their result slot, so the result register always
    // reflects exactly the enabled, legal loads of the current access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            lane_q   <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid && req_vector) begin
                        addr_q   <= base_addr;
                        stride_q <= stride;
                        mask_q   <= lane_mask;
                        wdata_q  <= wdata;
                        write_q  <= req_write;
                        lane_q   <= '0;
                        result_q <= '0;
                        fault_q  <= 1'b0;
                    end
                end
                XFER: begin
                    lane_q <= lane_q + LW'(1);
                    addr_q <= addr_q + stride_q;
                    result_q[int'(lane_q)*N +: N] <=
                        (lane_en && lane_in_range && !write_q) ? mem_rdata : '0;
                    if (lane_en && !lane_in_range) begin
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode. Everything defaults to zero so that the
    // reset override and every unlisted case drive a quiet memory port. The
    // DONE state returns to IDLE unconditionally: the pipeline advances on
    // that edge, so the request still visible in DONE is the finished one.
    always_comb begin
        state_next     = state;
        stall_cpu      = 1'b0;
        mem_wen_output = 1'b0;
        m_address      = '0;
        to_mem_data    = '0;
        output_vector  = '0;
        done           = 1'b0;
        addr_fault     = 1'b0;

        if (rst) begin
            addr_fault = fault_q;
            case (state)
                IDLE: begin
                    if (req_valid && req_vector) begin
                        stall_cpu  = 1'b1;
                        state_next = XFER;
                    end else if (req_valid) begin
                        m_address      = scalar_in_range ? base_addr : '0;
                        to_mem_data    = wdata[N-1:0];
                        mem_wen_output = req_write && scalar_in_range;
                        output_vector  = {{(V-N){1'b0}}, mem_rdata};
                    end
                end
                XFER: begin
                    stall_cpu = 1'b1;
                    if (lane_en && lane_in_range) begin
                        m_address      = addr_q;
                        to_mem_data    = wdata_q[int'(lane_q)*N +: N];
                        mem_wen_output = write_q;
                    end
                    if (lane_q == LAST_LANE) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    done          = 1'b1;
                    output_vector = result_q;
                    state_next    = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lsu_strided.sv
// tb_vector_lsu_strided
//
// Directed bench for vector_lsu_strided. Two instances share clock and
// reset: an L=4 unit for the single-access scenarios and an L=8 unit for
// back-to-back vector loads. Data memory reads are modelled as a fixed
// function of the address; writes are checked on the memory port in the
// cycle they are presented, i.e. before the edge that commits them.

module tb_vector_lsu_strided;

    logic clk;
    logic rst;

    // L = 4 instance
    logic          req_valid, req_write, req_vector;
    logic [31:0]   base_addr, stride;
    logic [3:0]    lane_mask;
    logic [127:0]  wdata;
    logic [31:0]   mem_rdata;
    logic          stall_cpu, mem_wen_output, done, addr_fault;
    logic [31:0]   m_address, to_mem_data;
    logic [127:0]  output_vector;

    // L = 8 instance
    logic          b_req_valid, b_req_write, b_req_vector;
    logic [31:0]   b_base_addr, b_stride;
    logic [7:0]    b_lane_mask;
    logic [255:0]  b_wdata;
    logic [31:0]   b_mem_rdata;
    logic          b_stall_cpu, b_mem_wen_output, b_done, b_addr_fault;
    logic [31:0]   b_m_address, b_to_mem_data;
    logic [255:0]  b_output_vector;

    int vectors;
    int miscompares;

    wire [67:0] obs4 = {stall_cpu, mem_wen_output, done, addr_fault, m_address, to_mem_data};
    wire [67:0] obs8 = {b_stall_cpu, b_mem_wen_output, b_done, b_addr_fault, b_m_address, b_to_mem_data};

    vector_lsu_strided #(.N(32), .L(4), .ADDR_MAX(32'h3D08F)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_vector     (req_vector),
        .base_addr      (base_addr),
        .stride         (stride),
        .lane_mask      (lane_mask),
        .wdata          (wdata),
        .mem_rdata      (mem_rdata),
        .stall_cpu      (stall_cpu),
        .mem_wen_output (mem_wen_output),
        .m_address      (m_address),
        .to_mem_data    (to_mem_data),
        .output_vector  (output_vector),
        .done           (done),
        .addr_fault     (addr_fault)
    );

    vector_lsu_strided #(.N(32), .L(8), .ADDR_MAX(32'h3D08F)) dut8 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (b_req_valid),
        .req_write      (b_req_write),
        .req_vector     (b_req_vector),
        .base_addr      (b_base_addr),
        .stride         (b_stride),
        .lane_mask      (b_lane_mask),
        .wdata          (b_wdata),
        .mem_rdata      (b_mem_rdata),
        .stall_cpu      (b_stall_cpu),
        .mem_wen_output (b_mem_wen_output),
        .m_address      (b_m_address),
        .to_mem_data    (b_to_mem_data),
        .output_vector  (b_output_vector),
        .done           (b_done),
        .addr_fault     (b_addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents for the L=4 unit: a few preloaded words, everything
    // else reads back the inverted address so stray reads are visible.
    function automatic logic [31:0] rd4(input logic [31:0] a);
        case (a)
            32'h1000: return 32'hA;
            32'hFF8:  return 32'hB;
            32'hFF0:  return 32'hC;
            32'hFE8:  return 32'hD;
            default:  return ~a;
        endcase
    endfunction

    function automatic logic [31:0] rd8(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    function automatic logic [67:0] pk(input logic s, input logic w, input logic d,
                                       input logic f, input logic [31:0] a,
                                       input logic [31:0] dat);
        return {s, w, d, f, a, dat};
    endfunction

    always_comb mem_rdata   = rd4(m_address);
    always_comb b_mem_rdata = rd8(b_m_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic vec,
                                 input logic [31:0] ba, input logic [31:0] st,
                                 input logic [3:0] m, input logic [127:0] wd);
        req_valid  = v;
        req_write  = w;
        req_vector = vec;
        base_addr  = ba;
        stride     = st;
        lane_mask  = m;
        wdata      = wd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h4, 4'hF, 128'h1234_5678);
        b_req_valid  = 1'b1;
        b_req_write  = 1'b0;
        b_req_vector = 1'b1;
        b_base_addr  = 32'h40;
        b_stride     = 32'h4;
        b_lane_mask  = 8'hFF;
        b_wdata      = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if ({obs4, output_vector} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_l4 cyc%0d: got %h / %h, required all zero", k, obs4, output_vector);
            end
            vectors++;
            if ({obs8, b_output_vector} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_l8 cyc%0d: got %h / %h, required all zero", k, obs8, b_output_vector);
            end
            tick();
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        b_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({obs4, output_vector} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %h / %h, required all zero", obs4, output_vector);
        end
        tick();
    endtask

    task automatic test_scalar();
        logic [31:0] sb [4];
        logic [31:0] sd [4];
        logic        sw [4];
        logic [67:0] ex [4];
        logic [31:0] er [4];
        sb = '{32'h100, 32'h3D08F, 32'h3D090, 32'h1000};
        sd = '{32'hDEADBEEF, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003};
        sw = '{1'b1, 1'b1, 1'b1, 1'b0};
        ex[0] = pk(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   32'hDEADBEEF);
        ex[1] = pk(1'b0, 1'b1, 1'b0, 1'b0, 32'h3D08F, 32'h0BAD0001);
        ex[2] = pk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0BAD0002);
        ex[3] = pk(1'b0, 1'b0, 1'b0, 1'b0, 32'h1000,  32'h0BAD0003);
        er    = '{~32'h100, ~32'h3D08F, 32'hFFFFFFFF, 32'hA};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, sw[k], 1'b0, sb[k], 32'h4, 4'hF,
                          {32'h77777777, 32'h66666666, 32'h55555555, sd[k]});
            @(negedge clk);
            vectors++;
            if (obs4 !== ex[k]) begin
                miscompares++;
                $display("[TB] FAIL scalar_port #%0d: got %h, required %h", k, obs4, ex[k]);
            end
            vectors++;
            if (output_vector !== {96'b0, er[k]}) begin
                miscompares++;
                $display("[TB] FAIL scalar_rdata #%0d: got %h, required %h", k, output_vector, {96'b0, er[k]});
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        vectors++;
        if ({obs4, output_vector} !== '0) begin
            miscompares++;
            $display("[TB] FAIL scalar_idle: got %h / %h, required all zero", obs4, output_vector);
        end
        tick();
    endtask

    task automatic test_vector_store();
        logic [67:0] ex;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 32'h4, 4'b1111,
                      {32'd4, 32'd3, 32'd2, 32'd1});
        for (int k = 0; k <= 6; k++) begin
            if (k == 6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            @(negedge clk);
            if (k == 0)      ex = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            else if (k <= 4) ex = pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * (k - 1)), 32'(k));
            else if (k == 5) ex = pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            else             ex = '0;
            vectors++;
            if (obs4 !== ex) begin
                miscompares++;
                $display("[TB] FAIL vstore cyc%0d: got %h, required %h", k, obs4, ex);
            end
            if (k >= 5) begin
                vectors++;
                if (output_vector !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL vstore_result cyc%0d: got %h, required 0", k, output_vector);
                end
            end
            tick();
        end
    endtask

    task automatic test_addr_fault();
        logic [67:0] ex [8];
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3D088, 32'h4, 4'b1111,
                      {32'h44, 32'h33, 32'h22, 32'h11});
        ex[0] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0);
        ex[1] = pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h3D088, 32'h11);
        ex[2] = pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h3D08C, 32'h22);
        ex[3] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0);
        ex[4] = pk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,     32'h0);
        ex[5] = pk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0,     32'h0);
        ex[6] = pk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,     32'h0);
        ex[7] = pk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,     32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            @(negedge clk);
            vectors++;
            if (obs4 !== ex[k]) begin
                miscompares++;
                $display("[TB] FAIL fault cyc%0d: got %h, required %h", k, obs4, ex[k]);
            end
            tick();
        end
    endtask

    task automatic test_vector_load();
        logic [67:0] ex [7];
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFF8, 4'b1011,
                      {32'd4, 32'd3, 32'd2, 32'd1});
        ex[0] = pk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0);
        ex[1] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h1);
        ex[2] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFF8,  32'h2);
        ex[3] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0);
        ex[4] = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'hFE8,  32'h4);
        ex[5] = pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    32'h0);
        ex[6] = '0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            @(negedge clk);
            vectors++;
            if (obs4 !== ex[k]) begin
                miscompares++;
                $display("[TB] FAIL vload cyc%0d: got %h, required %h", k, obs4, ex[k]);
            end
            if (k == 5) begin
                vectors++;
                if (output_vector !== {32'hD, 32'h0, 32'hB, 32'hA}) begin
                    miscompares++;
                    $display("[TB] FAIL vload_result: got %h, required %h", output_vector,
                             {32'hD, 32'h0, 32'hB, 32'hA});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic [67:0] ex;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 32'h4, 4'b1111,
                      {32'h4D, 32'h3C, 32'h2B, 32'h1A});
        for (int k = 0; k < 8; k++) begin
            if (k == 2) rst = 1'b0;
            if (k == 3) begin
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            end
            @(negedge clk);
            if (k == 0)      ex = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0);
            else if (k == 1) ex = pk(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h1A);
            else             ex = '0;
            vectors++;
            if (obs4 !== ex || (k >= 2 && output_vector !== '0)) begin
                miscompares++;
                $display("[TB] FAIL reset_mid cyc%0d: got %h / %h, required %h / 0", k, obs4, output_vector, ex);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  bases [2];
        logic [31:0]  strides [2];
        logic [7:0]   masks [2];
        logic [67:0]  ex;
        logic [255:0] exv;
        logic [31:0]  a;
        int           s;
        int           j;
        bases   = '{32'h2000, 32'h5000};
        strides = '{32'h10, 32'hFFFFFFFC};
        masks   = '{8'hFF, 8'b10100101};
        for (int k = 0; k < 22; k++) begin
            if (k == 0 || k == 10) begin
                s = k / 10;
                b_req_valid  = 1'b1;
                b_req_write  = 1'b0;
                b_req_vector = 1'b1;
                b_base_addr  = bases[s];
                b_stride     = strides[s];
                b_lane_mask  = masks[s];
                for (int i = 0; i < 8; i++) b_wdata[32*i +: 32] = 32'h100 * (s + 1) + 32'(i);
            end
            if (k == 20) b_req_valid = 1'b0;
            @(negedge clk);
            s   = k / 10;
            j   = k % 10;
            exv = '0;
            if (k >= 20) begin
                ex = '0;
            end else if (j == 0) begin
                ex = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (j <= 8) begin
                a = bases[s] + 32'(j - 1) * strides[s];
                if (masks[s][j-1])
                    ex = pk(1'b1, 1'b0, 1'b0, 1'b0, a, 32'h100 * (s + 1) + 32'(j - 1));
                else
                    ex = pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                ex = pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    a = bases[s] + 32'(i) * strides[s];
                    exv[32*i +: 32] = masks[s][i] ? rd8(a) : 32'h0;
                end
            end
            vectors++;
            if (obs8 !== ex) begin
                miscompares++;
                $display("[TB] FAIL b2b cyc%0d: got %h, required %h", k, obs8, ex);
            end
            if (j == 9 || k >= 20) begin
                vectors++;
                if (b_output_vector !== exv) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_result cyc%0d: got %h, required %h", k, b_output_vector, exv);
                end
            end
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scalar();
        test_vector_store();
        test_addr_fault();
        test_vector_load();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
